// File: rtl/motion_filter.sv
// motion_filter: turns the raw motion-detector levels (and optionally the
// manual jump button) into clean runner commands in the clk_33m domain.
// Inputs are synchronized, the jump/duck levels are debounced, and jump
// edges become single-cycle pulses followed by a cooldown. Ducking is held
// for a minimum time once entered.
// Optional feature: define MOTION_FILTER_BTN_EN to synchronize btn_jump and
// use its rising edges as jump events; otherwise btn_jump is ignored.
`timescale 1ns/1ps
module motion_filter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 330000,
   parameter int COOLDOWN_CYCLES = 16500000,
   parameter int DUCK_MIN_CYCLES = 3300000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       jumping_raw,
   input  logic       ducking_raw,
   input  logic       btn_jump,
   output logic       jump_pulse,
   output logic       ducking,
   output logic [1:0] state,
   output logic [7:0] jump_count
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
   localparam int DM_W = $clog2(DUCK_MIN_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
   localparam logic [DM_W-1:0] DM_LAST = DM_W'(DUCK_MIN_CYCLES - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_COOLDOWN = 2'd1;
   localparam logic [1:0] S_DUCK     = 2'd2;

   // Handshake: none. All commands are plain registered levels/pulses; a
   // consumer samples jump_pulse on every clk edge and must not miss one.

   logic [SYNC_STAGES-1:0] jump_sync_q, jump_sync_d;
   logic [SYNC_STAGES-1:0] duck_sync_q, duck_sync_d;
   logic [DB_W-1:0]        jump_cnt_q, jump_cnt_d;
   logic [DB_W-1:0]        duck_cnt_q, duck_cnt_d;
   logic                   jump_db_q, jump_db_d;
   logic                   duck_db_q, duck_db_d;
   logic                   jump_dly_q, jump_dly_d;
   logic                   jump_sync, duck_sync;
   logic                   btn_rise;
   logic                   jump_evt;

   logic [1:0]             state_q, state_d;
   logic                   pulse_q, pulse_d;
   logic                   ducking_q, ducking_d;
   logic [7:0]             count_q, count_d;
   logic [CD_W-1:0]        cd_cnt_q, cd_cnt_d;
   logic [DM_W-1:0]        dm_cnt_q, dm_cnt_d;

   assign jump_sync = jump_sync_q[SYNC_STAGES-1];
   assign duck_sync = duck_sync_q[SYNC_STAGES-1];

`ifdef MOTION_FILTER_BTN_EN
   logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
   logic                   btn_prev_q, btn_prev_d;

   // Button synchronizer plus one flop of history for edge detection.
   always_comb begin
      btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_jump};
      btn_prev_d = btn_sync_q[SYNC_STAGES-1];
   end

   // Button synchronizer and edge-history registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_sync_q <= '0;
         btn_prev_q <= 1'b0;
      end else begin
         btn_sync_q <= btn_sync_d;
         btn_prev_q <= btn_prev_d;
      end
   end

   assign btn_rise = btn_sync_q[SYNC_STAGES-1] & ~btn_prev_q;
`else
   // The button is not part of this build; keep the port but drop its logic.
   logic unused_btn_jump;
   assign unused_btn_jump = btn_jump;
   assign btn_rise        = 1'b0;
`endif

   // Synchronizers and debounce of the jump and duck levels.
   always_comb begin
      jump_sync_d = {jump_sync_q[SYNC_STAGES-2:0], jumping_raw};
      duck_sync_d = {duck_sync_q[SYNC_STAGES-2:0], ducking_raw};
      jump_dly_d  = jump_db_q;

      jump_db_d  = jump_db_q;
      jump_cnt_d = '0;
      if (jump_sync != jump_db_q) begin
         if (jump_cnt_q == DB_LAST) jump_db_d  = jump_sync;
         else                       jump_cnt_d = jump_cnt_q + DB_W'(1);
      end

      duck_db_d  = duck_db_q;
      duck_cnt_d = '0;
      if (duck_sync != duck_db_q) begin
         if (duck_cnt_q == DB_LAST) duck_db_d  = duck_sync;
         else                       duck_cnt_d = duck_cnt_q + DB_W'(1);
      end
   end

   // Input conditioning registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jump_sync_q <= '0;
         duck_sync_q <= '0;
         jump_cnt_q  <= '0;
         duck_cnt_q  <= '0;
         jump_db_q   <= 1'b0;
         duck_db_q   <= 1'b0;
         jump_dly_q  <= 1'b0;
      end else begin
         jump_sync_q <= jump_sync_d;
         duck_sync_q <= duck_sync_d;
         jump_cnt_q  <= jump_cnt_d;
         duck_cnt_q  <= duck_cnt_d;
         jump_db_q   <= jump_db_d;
         duck_db_q   <= duck_db_d;
         jump_dly_q  <= jump_dly_d;
      end
   end

   // Both sources firing together still make a single event.
   assign jump_evt = (jump_db_q & ~jump_dly_q) | btn_rise;

   // Command FSM: jump has priority, cooldown drops edges, duck has a min hold.
   always_comb begin
      state_d  = state_q;
      pulse_d  = 1'b0;
      cd_cnt_d = '0;
      dm_cnt_d = '0;
      count_d  = count_q;
      case (state_q)
         S_IDLE: begin
            if (jump_evt) begin
               pulse_d = 1'b1;
               state_d = S_COOLDOWN;
            end else if (duck_db_q) begin
               state_d = S_DUCK;
            end
         end
         S_COOLDOWN: begin
            if (cd_cnt_q == CD_LAST) state_d  = duck_db_q ? S_DUCK : S_IDLE;
            else                     cd_cnt_d = cd_cnt_q + CD_W'(1);
         end
         S_DUCK: begin
            if (jump_evt) begin
               pulse_d = 1'b1;
               state_d = S_COOLDOWN;
            end else begin
               // dm_cnt_q counts completed DUCK cycles; the current one is the +1.
               if (!duck_db_q && dm_cnt_q == DM_LAST) state_d = S_IDLE;
               dm_cnt_d = (dm_cnt_q == DM_LAST) ? dm_cnt_q : dm_cnt_q + DM_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pulse_d) count_d = count_q + 8'd1;
      ducking_d = (state_d == S_DUCK);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pulse_q   <= 1'b0;
         ducking_q <= 1'b0;
         count_q   <= 8'd0;
         cd_cnt_q  <= '0;
         dm_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         ducking_q <= ducking_d;
         count_q   <= count_d;
         cd_cnt_q  <= cd_cnt_d;
         dm_cnt_q  <= dm_cnt_d;
      end
   end

   assign jump_pulse = pulse_q;
   assign ducking    = ducking_q;
   assign state      = state_q;
   assign jump_count = count_q;

endmodule

// File: doc/motion_filter.md
# motion_filter

Conditions the raw motion-detector outputs and the manual jump button into clean game commands for the runner, in the clk_33m domain. It synchronizes and debounces the jumping/ducking levels, turns jump presses into single-cycle pulses with a cooldown, and enforces a minimum duck hold. A small status word goes to the seven-segment display.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flops per asynchronous input (≥2)
- DEBOUNCE_CYCLES, 330000, consecutive stable cycles before a debounced level changes (≥1)
- COOLDOWN_CYCLES, 16500000, cycles after a jump pulse during which jump edges are dropped (≥1)
- DUCK_MIN_CYCLES, 3300000, minimum cycles `ducking` stays high once asserted (≥1)

Ports:
- clk  in  1  33 MHz game clock
- reset_n  in  1  asynchronous reset, active-low
- jumping_raw  in  1  motion-detector jump level, asynchronous
- ducking_raw  in  1  motion-detector duck level, asynchronous
- btn_jump  in  1  board-debounced manual jump button, asynchronous, 1 = pressed
- jump_pulse  out  1  one-cycle jump command
- ducking  out  1  duck command level
- state  out  2  FSM state: 0 IDLE, 1 COOLDOWN, 2 DUCK
- jump_count  out  8  number of emitted jump pulses

## Operation
- Each of jumping_raw, ducking_raw and btn_jump passes through its own SYNC_STAGES synchronizer.
- Debounce applies to the jump and duck paths only. Each path has a counter and a debounced register:
  - When the synchronized value ≠ the debounced value, the counter increments.
  - When it reaches DEBOUNCE_CYCLES−1 and the mismatch still holds, the debounced value takes the new level and the counter clears.
  - Any cycle with a match clears the counter.
- Jump event:
  - A rising edge of debounced jump, or a rising edge of synchronized btn_jump (see Configuration), is a jump event.
  - Simultaneous events from both sources count as one jump event.
- FSM:
  - IDLE: a jump event emits jump_pulse and moves to COOLDOWN. If there is no jump event and debounced duck = 1, move to DUCK. Jump takes priority over duck.
  - COOLDOWN: stays exactly COOLDOWN_CYCLES cycles. ducking = 0. Jump events are dropped, not queued. On exit, go to DUCK if debounced duck = 1, otherwise go to IDLE.
  - DUCK: ducking = 1. A jump event preempts the duck: pulse, ducking drops, move to COOLDOWN. Otherwise leave for IDLE only when debounced duck = 0 and at least DUCK_MIN_CYCLES cycles have been spent in DUCK.
- jump_count increments by 1 per jump_pulse and wraps 255→0.
- Reset values:
  - jump_pulse = 0, ducking = 0, state = IDLE, jump_count = 0.
  - All synchronizer flops, debounced registers and counters = 0.
- Reset mid-operation:
  - Clears immediately and asynchronously, with no pulse.
  - An input still held high at release is seen as a new press and produces a pulse after the normal latency.

## Timing
- All outputs are registered.
- jumping_raw rise → jump_pulse: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- btn_jump rise → jump_pulse: SYNC_STAGES + 1 cycles.
- ducking_raw rise → ducking: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles, when in IDLE.
- jump_pulse is high for exactly 1 cycle. state reads COOLDOWN in the same cycle.
- Counter widths are $clog2(param+1). There is no overflow, because counters saturate at their terminal value.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes a debounced value.

## Configuration
- MOTION_FILTER_BTN_EN defined: btn_jump is synchronized and its rising edges are jump events.
- MOTION_FILTER_BTN_EN undefined:
  - The btn_jump port stays present but is ignored, and its synchronizer is not built.
  - Jumps come only from jumping_raw.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10, DUCK_MIN_CYCLES=6, with MOTION_FILTER_BTN_EN defined.
- Jump latency: jumping_raw 0→1 held → jump_pulse high exactly 1 cycle, 7 cycles after the edge. jump_count = 1, then state = COOLDOWN for 10 cycles, then IDLE.
- Glitch rejection: 3-cycle pulses on jumping_raw and ducking_raw → no jump_pulse, ducking stays 0, state stays IDLE.
- Cooldown drop:
  - Button presses (btn_jump rises) at cycle 0 and cycle 5 → exactly one pulse, at cycle 3. jump_count = 1.
  - A third press at cycle 20 → second pulse at cycle 23.
- Duck minimum hold: ducking_raw high for 5 cycles → ducking rises at cycle 7, state = DUCK, and ducking stays high for ≥6 cycles before state returns to IDLE.
- Jump preempts duck: in DUCK, btn_jump rises → jump_pulse 3 cycles later and ducking low on that same cycle. With ducking_raw still high, state goes COOLDOWN → DUCK after 10 cycles.
- Async reset: reset_n low in the middle of COOLDOWN → all outputs 0 within the same cycle. With jumping_raw held high at release, a pulse arrives 7 cycles after release and jump_count = 1.
